// File: rtl/snake_pkg.sv
// snake_pkg: direction codes, scheduler states and direction helpers shared by the snake datapath
package snake_pkg;

    typedef logic [2:0] dir_t;

    localparam dir_t DIR_RIGHT = 3'b000;
    localparam dir_t DIR_DOWN  = 3'b001;
    localparam dir_t DIR_LEFT  = 3'b010;
    localparam dir_t DIR_UP    = 3'b011;
    localparam dir_t DIR_NONE  = 3'b100;

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    // Opposite codes differ only in bit 1; NONE has no opposite
    function automatic dir_t dir_reverse(input dir_t d);
        return (d == DIR_NONE) ? DIR_NONE : (d ^ 3'b010);
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// dir_fifo: small turn queue exposing both head (next to commit) and tail (last queued)
module dir_fifo
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  dir_t                     data,
    output dir_t                     head,
    output dir_t                     tail,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    dir_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, tail_ptr;
    logic do_push, do_pop;

    always_comb begin
        full     = count == CW'(DEPTH);
        empty    = count == '0;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        tail_ptr = wr_ptr - AW'(1);
        head     = mem[rd_ptr];
        tail     = mem[tail_ptr];
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk)
        if (do_push && !flush && !reset)
            mem[wr_ptr] <= data;

endmodule

// File: rtl/direction_scheduler.sv
// direction_scheduler: filters button direction changes into a turn queue and commits one turn per move tick
module direction_scheduler
    import snake_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               dir_in,
    input  logic                     move_tick,
    input  logic                     game_over,
    output logic [2:0]               dir_out,
    output logic                     step,
    output logic [$clog2(DEPTH):0]   queue_count,
    output logic                     drop
);
    state_t state, state_next;
    dir_t dir_prev, head, tail, ref_dir;
    logic full, empty, active, cand, legal, push, pop, flush, step_next, drop_next;

    dir_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .data  (dir_in),
        .head  (head),
        .tail  (tail),
        .count (queue_count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_next;

    always_comb begin
        state_next = state;
        if (state != HALT && game_over)
            state_next = HALT;
        else if (state == IDLE && move_tick && !empty)
            state_next = RUN;
    end

    // New turns are checked against the last queued turn so chained presses stay consistent
    always_comb begin
        active    = state != HALT && !game_over;
        flush     = !active;
        ref_dir   = empty ? dir_out : tail;
        cand      = dir_in != dir_prev && dir_in != DIR_NONE;
        legal     = ref_dir == DIR_NONE || (dir_in != ref_dir && dir_in != dir_reverse(ref_dir));
        push      = active && cand && legal && !full;
        drop_next = active && cand && (!legal || full);
        pop       = active && move_tick && !empty;
        step_next = active && move_tick && (state == RUN || !empty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dir_prev <= DIR_NONE;
            dir_out  <= DIR_NONE;
            step     <= 1'b0;
            drop     <= 1'b0;
        end else begin
            dir_prev <= dir_in;
            dir_out  <= pop ? head : dir_out;
            step     <= step_next;
            drop     <= drop_next;
        end
    end

endmodule

// File: tb/tb_direction_scheduler.sv
// tb_direction_scheduler: cycle-by-cycle directed vectors for the direction scheduler
module tb_direction_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] dir_in;
    logic       move_tick;
    logic       game_over;
    logic [2:0] dir_out;
    logic       step;
    logic [2:0] queue_count;
    logic       drop;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic       rst;
        logic [2:0] din;
        logic       tick;
        logic       go;
        logic [2:0] e_dir;
        logic       e_step;
        logic [2:0] e_cnt;
        logic       e_drop;
    } vec_t;

    vec_t vecs[$];

    direction_scheduler #(.DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .dir_in      (dir_in),
        .move_tick   (move_tick),
        .game_over   (game_over),
        .dir_out     (dir_out),
        .step        (step),
        .queue_count (queue_count),
        .drop        (drop)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [2:0] din, input logic tick, input logic go,
                       input logic [2:0] e_dir, input logic e_step, input logic [2:0] e_cnt, input logic e_drop);
        vec_t v;
        v = '{rst, din, tick, go, e_dir, e_step, e_cnt, e_drop};
        vecs.push_back(v);
    endtask

    task automatic apply(input string name, input vec_t v);
        reset     = v.rst;
        dir_in    = v.din;
        move_tick = v.tick;
        game_over = v.go;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({dir_out, step, queue_count, drop} !== {v.e_dir, v.e_step, v.e_cnt, v.e_drop}) begin
            n_miss++;
            $display("FAIL %s: got dir=%b step=%b cnt=%0d drop=%b, want dir=%b step=%b cnt=%0d drop=%b",
                     name, dir_out, step, queue_count, drop, v.e_dir, v.e_step, v.e_cnt, v.e_drop);
        end
    endtask

    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++)
            apply($sformatf("vec%0d", i), vecs[i]);
    endtask

    initial begin
        // rst din tick go | dir step cnt drop
        add(1, 3'd4, 0, 0, 3'd4, 0, 0, 0);  // 0 reset state
        add(0, 3'd3, 0, 0, 3'd4, 0, 1, 0);  // 1 up queued
        add(0, 3'd3, 1, 0, 3'd3, 1, 0, 0);  // 2 first tick commits up, RUN
        add(0, 3'd3, 0, 0, 3'd3, 0, 0, 0);  // 3 step is a pulse
        add(0, 3'd3, 1, 0, 3'd3, 1, 0, 0);  // 4 tick, hold
        add(0, 3'd3, 1, 0, 3'd3, 1, 0, 0);  // 5 tick, hold
        add(0, 3'd3, 0, 0, 3'd3, 0, 0, 0);  // 6
        add(0, 3'd0, 0, 0, 3'd3, 0, 1, 0);  // 7 right queued
        add(0, 3'd0, 1, 0, 3'd0, 1, 0, 0);  // 8 dir_out=right
        add(0, 3'd3, 0, 0, 3'd0, 0, 1, 0);  // 9 up
        add(0, 3'd2, 0, 0, 3'd0, 0, 2, 0);  // 10 left legal against queued up
        add(0, 3'd2, 1, 0, 3'd3, 1, 1, 0);  // 11
        add(0, 3'd2, 0, 0, 3'd3, 0, 1, 0);  // 12
        add(0, 3'd2, 1, 0, 3'd2, 1, 0, 0);  // 13
        add(0, 3'd3, 0, 0, 3'd2, 0, 1, 0);  // 14
        add(0, 3'd0, 0, 0, 3'd2, 0, 2, 0);  // 15
        add(0, 3'd0, 1, 0, 3'd3, 1, 1, 0);  // 16
        add(0, 3'd0, 1, 0, 3'd0, 1, 0, 0);  // 17 dir_out=right, empty
        add(0, 3'd2, 0, 0, 3'd0, 0, 0, 1);  // 18 reversal dropped
        add(0, 3'd2, 1, 0, 3'd0, 1, 0, 0);  // 19 dir_out holds
        add(0, 3'd0, 0, 0, 3'd0, 0, 0, 1);  // 20 repeat of dir_out dropped
        add(0, 3'd1, 0, 0, 3'd0, 0, 1, 0);  // 21 fill queue
        add(0, 3'd2, 0, 0, 3'd0, 0, 2, 0);  // 22
        add(0, 3'd3, 0, 0, 3'd0, 0, 3, 0);  // 23
        add(0, 3'd0, 0, 0, 3'd0, 0, 4, 0);  // 24 full
        add(0, 3'd1, 0, 0, 3'd0, 0, 4, 1);  // 25 full drop
        add(0, 3'd3, 1, 0, 3'd1, 1, 3, 1);  // 26 push+pop at full: pop only
        add(0, 3'd3, 1, 0, 3'd2, 1, 2, 0);  // 27 count 2
        add(0, 3'd3, 1, 1, 3'd2, 0, 0, 0);  // 28 game_over beats tick
        add(1, 3'd4, 0, 0, 3'd4, 0, 0, 0);  // 29 reset out of HALT
        add(0, 3'd0, 0, 0, 3'd4, 0, 1, 0);  // 30
        add(0, 3'd0, 1, 0, 3'd0, 1, 0, 0);  // 31 RUN, empty
        add(0, 3'd3, 1, 0, 3'd0, 1, 1, 0);  // 32 push+tick at empty: no pop
        add(0, 3'd3, 0, 0, 3'd0, 0, 1, 0);  // 33
        add(0, 3'd3, 1, 0, 3'd3, 1, 0, 0);  // 34 queued turn commits
        add(0, 3'd2, 0, 0, 3'd3, 0, 1, 0);  // 35
        add(1, 3'd2, 0, 0, 3'd4, 0, 0, 0);  // 36 reset mid-run clears queue
        add(0, 3'd2, 1, 0, 3'd4, 0, 1, 0);  // 37 IDLE tick with empty queue ignored
        add(0, 3'd2, 1, 0, 3'd2, 1, 0, 0);  // 38

        reset = 1'b1; dir_in = 3'd4; move_tick = 1'b0; game_over = 1'b0;
        @(negedge clk);
        run_range(0, 28);
        // HALT: direction churn and ticks must produce nothing
        for (int i = 0; i < 8; i++) begin
            vec_t h;
            h = '{1'b0, 3'(i % 4), i[0], 1'b0, 3'd2, 1'b0, 3'd0, 1'b0};
            apply($sformatf("halt%0d", i), h);
        end
        run_range(29, vecs.size() - 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
